// File: rtl/crypto_seq_ctrl.sv
// Job sequencer for the AES accelerator: loads the key from the key buffer, then streams
// the data buffer through the core one 128-bit block at a time into the result buffer.
module crypto_seq_ctrl #(
    parameter int BUS_WIDTH  = 32,
    parameter int BUF_ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [15:0]           key_len_i,
    input  logic [15:0]           data_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           result_len_o,
    output logic                  key_rd_en_o,
    output logic [BUF_ADDR_W-1:0] key_rd_addr_o,
    input  logic [BUS_WIDTH-1:0]  key_rd_data_i,
    output logic                  dat_rd_en_o,
    output logic [BUF_ADDR_W-1:0] dat_rd_addr_o,
    input  logic [BUS_WIDTH-1:0]  dat_rd_data_i,
    output logic                  res_wr_en_o,
    output logic [BUF_ADDR_W-1:0] res_wr_addr_o,
    output logic [BUS_WIDTH-1:0]  res_wr_data_o,
    output logic [255:0]          aes_key_o,
    output logic [1:0]            aes_key_size_o,
    output logic                  aes_key_load_o,
    output logic                  aes_in_valid_o,
    input  logic                  aes_in_ready_i,
    output logic [127:0]          aes_block_o,
    input  logic                  aes_out_valid_i,
    input  logic [127:0]          aes_out_block_i
);

    localparam int unsigned MAX_BYTES = 4 * (2 ** BUF_ADDR_W);

    typedef enum logic [3:0] {
        IDLE, CHECK, KEY_RD, KEY_LOAD, BLK_RD, ISSUE, WAIT, RES_WR, DONE, ERR
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   key_len_q, data_len_q;
    logic [15:0]   blk_q;
    logic [15:0]   result_len_q;
    logic          err_q;
    logic [1:0]    key_size_q;
    logic [255:0]  aes_key_q;
    logic [127:0]  blk_data_q;
    logic [127:0]  res_q;

    logic          start_acc;
    logic          cfg_ok;
    logic          last_blk;
    logic [3:0]    key_words;
    logic [2:0]    key_idx;

    assign start_acc = (state_q == IDLE) && start_i && !abort_i;
    assign key_words = key_len_q[5:2];
    assign key_idx   = 3'(cnt_q - 4'd1);
    assign last_blk  = (blk_q + 16'd1) == {4'b0000, data_len_q[15:4]};
    assign cfg_ok    = (key_len_q == 16'd16 || key_len_q == 16'd24 || key_len_q == 16'd32)
                    && (data_len_q != 16'd0) && (data_len_q[3:0] == 4'd0)
                    && (32'(data_len_q) <= MAX_BYTES);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE:     if (start_i) state_d = CHECK;
            CHECK:    state_d = cfg_ok ? KEY_RD : ERR;
            KEY_RD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == key_words) state_d = KEY_LOAD;
            end
            KEY_LOAD: state_d = BLK_RD;
            BLK_RD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd4) state_d = ISSUE;
            end
            ISSUE:    if (aes_in_ready_i) state_d = WAIT;
            WAIT:     if (aes_out_valid_i) state_d = RES_WR;
            RES_WR: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd3) state_d = last_blk ? DONE : BLK_RD;
            end
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Abort wins over every other transition, including a same-cycle start.
        if (abort_i) state_d = IDLE;
        if (state_d != state_q) cnt_d = '0;
    end

    // NOTE: datapath registers are reset too, because the core-facing outputs must read zero in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_len_q    <= '0;
            data_len_q   <= '0;
            blk_q        <= '0;
            result_len_q <= '0;
            err_q        <= 1'b0;
            key_size_q   <= '0;
            aes_key_q    <= '0;
            blk_data_q   <= '0;
            res_q        <= '0;
        end else begin
            if (start_acc) begin
                key_len_q    <= key_len_i;
                data_len_q   <= data_len_i;
                err_q        <= 1'b0;
                result_len_q <= '0;
                blk_q        <= '0;
                aes_key_q    <= '0;
            end
            if (!abort_i) begin
                unique case (state_q)
                    KEY_RD: begin
                        // Read data lags the strobe by one cycle, so word i lands at count i+1.
                        if (cnt_q != 4'd0)
                            aes_key_q[(7 - int'(key_idx)) * BUS_WIDTH +: BUS_WIDTH] <= key_rd_data_i;
                        if (state_d == KEY_LOAD)
                            key_size_q <= (key_len_q == 16'd16) ? 2'd0 :
                                          (key_len_q == 16'd24) ? 2'd1 : 2'd2;
                    end
                    BLK_RD:
                        if (cnt_q != 4'd0) blk_data_q <= {blk_data_q[95:0], dat_rd_data_i};
                    WAIT:
                        if (aes_out_valid_i) res_q <= aes_out_block_i;
                    RES_WR:
                        if (cnt_q == 4'd3) begin
                            result_len_q <= result_len_q + 16'd16;
                            blk_q        <= blk_q + 16'd1;
                        end
                    ERR:     err_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        key_rd_en_o    = 1'b0;
        key_rd_addr_o  = '0;
        dat_rd_en_o    = 1'b0;
        dat_rd_addr_o  = '0;
        res_wr_en_o    = 1'b0;
        res_wr_addr_o  = '0;
        res_wr_data_o  = '0;
        aes_key_load_o = 1'b0;
        aes_in_valid_o = 1'b0;
        unique case (state_q)
            KEY_RD:
                if (cnt_q < key_words) begin
                    key_rd_en_o   = 1'b1;
                    key_rd_addr_o = BUF_ADDR_W'(cnt_q);
                end
            KEY_LOAD: aes_key_load_o = 1'b1;
            BLK_RD:
                if (cnt_q < 4'd4) begin
                    dat_rd_en_o   = 1'b1;
                    dat_rd_addr_o = {blk_q[BUF_ADDR_W-3:0], cnt_q[1:0]};
                end
            ISSUE:    aes_in_valid_o = 1'b1;
            RES_WR: begin
                res_wr_en_o   = 1'b1;
                res_wr_addr_o = {blk_q[BUF_ADDR_W-3:0], cnt_q[1:0]};
                res_wr_data_o = res_q[(3 - int'(cnt_q[1:0])) * BUS_WIDTH +: BUS_WIDTH];
            end
            default: ;
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign err_o          = err_q;
    assign result_len_o   = result_len_q;
    assign aes_key_o      = aes_key_q;
    assign aes_key_size_o = key_size_q;
    assign aes_block_o    = blk_data_q;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Directed bench for crypto_seq_ctrl with buffer, core and bus-monitor models around the DUT.
module tb_crypto_seq_ctrl;

    localparam int AW = 10;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i, abort_i;
    logic [15:0]   key_len_i, data_len_i;
    logic          busy_o, done_o, err_o;
    logic [15:0]   result_len_o;
    logic          key_rd_en_o, dat_rd_en_o, res_wr_en_o;
    logic [AW-1:0] key_rd_addr_o, dat_rd_addr_o, res_wr_addr_o;
    logic [31:0]   key_rd_data_i, dat_rd_data_i, res_wr_data_o;
    logic [255:0]  aes_key_o;
    logic [1:0]    aes_key_size_o;
    logic          aes_key_load_o, aes_in_valid_o, aes_in_ready_i, aes_out_valid_i;
    logic [127:0]  aes_block_o, aes_out_block_i;

    crypto_seq_ctrl #(.BUS_WIDTH(32), .BUF_ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .key_len_i(key_len_i), .data_len_i(data_len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_len_o(result_len_o),
        .key_rd_en_o(key_rd_en_o), .key_rd_addr_o(key_rd_addr_o), .key_rd_data_i(key_rd_data_i),
        .dat_rd_en_o(dat_rd_en_o), .dat_rd_addr_o(dat_rd_addr_o), .dat_rd_data_i(dat_rd_data_i),
        .res_wr_en_o(res_wr_en_o), .res_wr_addr_o(res_wr_addr_o), .res_wr_data_o(res_wr_data_o),
        .aes_key_o(aes_key_o), .aes_key_size_o(aes_key_size_o), .aes_key_load_o(aes_key_load_o),
        .aes_in_valid_o(aes_in_valid_o), .aes_in_ready_i(aes_in_ready_i), .aes_block_o(aes_block_o),
        .aes_out_valid_i(aes_out_valid_i), .aes_out_block_i(aes_out_block_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    // Monitor counters and write log
    int            n_key_rd, n_dat_rd, n_wr, n_load, n_valid, n_unstable, n_overlap, n_done, n_accept;
    logic [1:0]    load_size;
    logic [AW-1:0] wr_addr_log [0:63];
    logic [31:0]   wr_data_log [0:63];
    logic          prev_valid;
    logic [127:0]  prev_block;

    // Core model controls
    int            ready_delay, out_delay, rdy_cnt, out_cnt, resp_budget;
    bit            pending, inject_out;
    logic [127:0]  resp;

    // Buffer model: read data follows the strobe by one cycle
    logic          k_en, d_en;
    logic [AW-1:0] k_a, d_a;

    initial begin
        key_rd_data_i = '0;
        dat_rd_data_i = '0;
        forever begin
            @(negedge clk_i);
            k_en = key_rd_en_o; k_a = key_rd_addr_o;
            d_en = dat_rd_en_o; d_a = dat_rd_addr_o;
            @(posedge clk_i);
            #1;
            if (k_en) key_rd_data_i = 32'hC0DE_0000 | 32'(k_a);
            if (d_en) dat_rd_data_i = 32'hD000_0000 | 32'(d_a);
        end
    end

    // AES core model: result block is the bitwise inverse of the accepted block
    initial begin
        aes_in_ready_i  = 1'b0;
        aes_out_valid_i = 1'b0;
        aes_out_block_i = '0;
        forever begin
            @(negedge clk_i);
            aes_out_valid_i = 1'b0;
            if (!rst_ni) begin
                aes_in_ready_i = 1'b0;
                pending = 1'b0;
                rdy_cnt = 0;
            end else begin
                if (aes_in_valid_o) begin
                    if (rdy_cnt >= ready_delay) aes_in_ready_i = 1'b1;
                    else rdy_cnt++;
                end else begin
                    if (aes_in_ready_i) begin
                        pending = 1'b1;
                        out_cnt = 0;
                        resp = ~aes_block_o;
                        n_accept++;
                    end
                    aes_in_ready_i = 1'b0;
                    rdy_cnt = 0;
                end
                if (inject_out) begin
                    aes_out_valid_i = 1'b1;
                    aes_out_block_i = '1;
                    inject_out = 1'b0;
                end else if (pending && resp_budget > 0) begin
                    if (out_cnt >= out_delay) begin
                        aes_out_valid_i = 1'b1;
                        aes_out_block_i = resp;
                        pending = 1'b0;
                        resp_budget--;
                    end else begin
                        out_cnt++;
                    end
                end
            end
        end
    end

    // Bus monitor
    initial begin
        prev_valid = 1'b0;
        prev_block = '0;
        forever begin
            @(negedge clk_i);
            if (key_rd_en_o) n_key_rd++;
            if (dat_rd_en_o) n_dat_rd++;
            if (32'(key_rd_en_o) + 32'(dat_rd_en_o) + 32'(res_wr_en_o) > 1) n_overlap++;
            if (aes_key_load_o) begin
                n_load++;
                load_size = aes_key_size_o;
            end
            if (res_wr_en_o) begin
                if (n_wr < 64) begin
                    wr_addr_log[n_wr] = res_wr_addr_o;
                    wr_data_log[n_wr] = res_wr_data_o;
                end
                n_wr++;
            end
            if (aes_in_valid_o) begin
                n_valid++;
                if (prev_valid && aes_block_o !== prev_block) n_unstable++;
            end
            prev_valid = aes_in_valid_o;
            prev_block = aes_block_o;
            if (done_o) n_done++;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic clear_counts();
        n_key_rd = 0; n_dat_rd = 0; n_wr = 0; n_load = 0; n_valid = 0;
        n_unstable = 0; n_overlap = 0; n_done = 0; n_accept = 0; load_size = 2'd3;
    endtask

    task automatic start_job(input logic [15:0] klen, input logic [15:0] dlen);
        key_len_i  = klen;
        data_len_i = dlen;
        start_i    = 1'b1;
        step(1);
        start_i    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy_o && n < budget) begin
            step(1);
            n++;
        end
        check({tag, " finish"}, 256'(busy_o), 256'(0));
    endtask

    // Writes must hit addresses 0,1,2,.. in order, each carrying the inverse of the matching data word.
    task automatic check_writes(input int count, input string tag);
        int bad_addr = 0, bad_data = 0;
        for (int k = 0; k < count && k < 64; k++) begin
            if (wr_addr_log[k] !== AW'(k)) bad_addr++;
            if (wr_data_log[k] !== ~(32'hD000_0000 | 32'(k))) bad_data++;
        end
        check({tag, " wr_order"}, 256'(bad_addr), 256'(0));
        check({tag, " wr_data"}, 256'(bad_data), 256'(0));
    endtask

    typedef struct { logic [15:0] klen; logic [15:0] dlen; } err_vec_t;
    err_vec_t err_vecs [4];
    int cyc;

    initial begin
        start_i = 1'b0; abort_i = 1'b0; key_len_i = '0; data_len_i = '0;
        ready_delay = 0; out_delay = 0; resp_budget = 100000;
        pending = 1'b0; inject_out = 1'b0; rdy_cnt = 0; out_cnt = 0;
        clear_counts();
        err_vecs[0] = '{16'd20, 16'd16};
        err_vecs[1] = '{16'd16, 16'd0};
        err_vecs[2] = '{16'd16, 16'd24};
        err_vecs[3] = '{16'd16, 16'd4112};

        // Reset state
        step(3);
        check("rst busy", 256'(busy_o), 256'(0));
        check("rst outs", 256'({done_o, err_o, key_rd_en_o, dat_rd_en_o, res_wr_en_o,
                                aes_key_load_o, aes_in_valid_o, aes_key_size_o}), 256'(0));
        check("rst result_len", 256'(result_len_o), 256'(0));
        check("rst aes_key", aes_key_o, 256'(0));
        rst_ni = 1'b1;
        step(2);

        // Single block, 128-bit key, core ready at once
        clear_counts();
        start_job(16'd16, 16'd16);
        wait_idle(200, "t1");
        check("t1 key_load count", 256'(n_load), 256'(1));
        check("t1 key_size", 256'(load_size), 256'(0));
        check("t1 key", aes_key_o,
              256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_00000000_00000000_00000000_00000000);
        check("t1 key reads", 256'(n_key_rd), 256'(4));
        check("t1 writes", 256'(n_wr), 256'(4));
        check_writes(4, "t1");
        check("t1 result_len", 256'(result_len_o), 256'(16));
        check("t1 done count", 256'(n_done), 256'(1));
        check("t1 valid cycles", 256'(n_valid), 256'(1));
        check("t1 err", 256'(err_o), 256'(0));

        // Four blocks, 256-bit key, ready delayed 3 cycles per block
        ready_delay = 3;
        clear_counts();
        start_job(16'd32, 16'd64);
        wait_idle(1000, "t2");
        check("t2 key_size", 256'(load_size), 256'(2));
        check("t2 key", aes_key_o,
              256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007);
        check("t2 writes", 256'(n_wr), 256'(16));
        check_writes(16, "t2");
        check("t2 result_len", 256'(result_len_o), 256'(64));
        check("t2 valid cycles", 256'(n_valid), 256'(16));
        check("t2 block stable", 256'(n_unstable), 256'(0));
        check("t2 data reads", 256'(n_dat_rd), 256'(16));
        check("t2 done count", 256'(n_done), 256'(1));
        ready_delay = 0;

        // Illegal lengths: error with no strobes, busy drops quickly
        foreach (err_vecs[i]) begin
            clear_counts();
            start_job(err_vecs[i].klen, err_vecs[i].dlen);
            cyc = 1;
            while (busy_o && cyc < 10) begin
                step(1);
                cyc++;
            end
            check($sformatf("t3.%0d busy fall", i), 256'(cyc <= 3), 256'(1));
            check($sformatf("t3.%0d err", i), 256'(err_o), 256'(1));
            check($sformatf("t3.%0d strobes", i),
                  256'(n_key_rd + n_dat_rd + n_wr + n_load + n_valid), 256'(0));
            check($sformatf("t3.%0d done", i), 256'(n_done), 256'(0));
        end

        // Largest legal data length; the accepted start also clears the sticky error
        clear_counts();
        start_job(16'd16, 16'd4096);
        check("t3 err cleared", 256'(err_o), 256'(0));
        wait_idle(5000, "t3 max");
        check("t3 max writes", 256'(n_wr), 256'(1024));
        check("t3 max result_len", 256'(result_len_o), 256'(4096));
        check("t3 max overlap", 256'(n_overlap), 256'(0));

        // Abort while waiting for the second of four result blocks
        clear_counts();
        resp_budget = 1;
        start_job(16'd16, 16'd64);
        cyc = 0;
        while (n_accept < 2 && cyc < 500) begin
            step(1);
            cyc++;
        end
        check("t4 reached block 2", 256'(n_accept), 256'(2));
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        check("t4 idle after abort", 256'(busy_o), 256'(0));
        check("t4 partial len", 256'(result_len_o), 256'(16));
        check("t4 err", 256'(err_o), 256'(0));
        step(3);
        check("t4 writes", 256'(n_wr), 256'(4));
        check("t4 no done", 256'(n_done), 256'(0));
        pending = 1'b0;
        resp_budget = 100000;
        clear_counts();
        start_job(16'd16, 16'd16);
        check("t4 len cleared", 256'(result_len_o), 256'(0));
        wait_idle(200, "t4 restart");
        check("t4 restart len", 256'(result_len_o), 256'(16));
        check("t4 restart done", 256'(n_done), 256'(1));

        // Asynchronous reset in the middle of a result write
        clear_counts();
        start_job(16'd16, 16'd32);
        cyc = 0;
        while (!res_wr_en_o && cyc < 500) begin
            step(1);
            cyc++;
        end
        check("t5 reached res_wr", 256'(res_wr_en_o), 256'(1));
        #1 rst_ni = 1'b0;
        #1;
        check("t5 busy", 256'(busy_o), 256'(0));
        check("t5 strobes", 256'({res_wr_en_o, res_wr_data_o, res_wr_addr_o, done_o, err_o}), 256'(0));
        check("t5 result_len", 256'(result_len_o), 256'(0));
        check("t5 aes_key", aes_key_o, 256'(0));
        check("t5 aes_block", 256'(aes_block_o), 256'(0));
        step(2);
        rst_ni = 1'b1;
        step(1);
        clear_counts();
        start_job(16'd24, 16'd32);
        wait_idle(300, "t5 after");
        check("t5 key_size", 256'(load_size), 256'(1));
        check("t5 key", aes_key_o,
              256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_00000000_00000000);
        check("t5 writes", 256'(n_wr), 256'(8));
        check_writes(8, "t5");
        check("t5 result_len", 256'(result_len_o), 256'(32));
        check("t5 done", 256'(n_done), 256'(1));

        // Stray result in IDLE and a second start during BLK_RD are both ignored
        clear_counts();
        inject_out = 1'b1;
        step(3);
        check("t6 stray busy", 256'(busy_o), 256'(0));
        check("t6 stray writes", 256'(n_wr), 256'(0));
        check("t6 stray len", 256'(result_len_o), 256'(32));
        start_job(16'd16, 16'd32);
        cyc = 0;
        while (!dat_rd_en_o && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("t6 reached blk_rd", 256'(dat_rd_en_o), 256'(1));
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        wait_idle(300, "t6");
        check("t6 writes", 256'(n_wr), 256'(8));
        check_writes(8, "t6");
        check("t6 result_len", 256'(result_len_o), 256'(32));
        check("t6 done", 256'(n_done), 256'(1));
        check("t6 overlap", 256'(n_overlap), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
